// File: rtl/mips_debug_dump_sequencer.sv
// rtl/mips_debug_dump_sequencer.sv - walks GPR/PC/latch/memory debug selects and queues replies in a FWFT FIFO
// Optional MIPS_DUMP_HEADER_EN: push a tag word {8'hA5,2'b00,select,idx} ahead of each item's data.
module mips_debug_dump_sequencer #(
   parameter int NB_DATA      = 32,
   parameter int NB_SEL       = 6,
   parameter int NB_MEM_ADDR  = 16,
   parameter int NB_GPR       = 32,
   parameter int NB_MEM_WORDS = 16,
   parameter int MAX_WORDS    = 3,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic                           i_start,
   input  logic                           i_abort,
   output logic [NB_SEL-1:0]              o_request_select,
   output logic [NB_MEM_ADDR-1:0]         o_mem_addr,
   input  logic [NB_DATA-1:0]             i_data_from_mips,
   input  logic                           i_eod,
   output logic [NB_DATA-1:0]             o_fifo_data,
   output logic                           o_fifo_valid,
   input  logic                           i_fifo_ready,
   output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_overrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(MAX_WORDS + 1);
   localparam int N_ITEMS = NB_GPR + 9 + NB_MEM_WORDS;
`ifdef MIPS_DUMP_HEADER_EN
   localparam int SPACE = MAX_WORDS + 1;
`else
   localparam int SPACE = MAX_WORDS;
`endif

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_REQ   = 3'd2;
   localparam logic [2:0] S_CAP   = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [NB_SEL-1:0] SEL_NONE   = '1;
   localparam logic [NB_SEL-1:0] SEL_MEM    = NB_SEL'(6'b100000);
   localparam logic [NB_SEL-1:0] SEL_PC     = NB_SEL'(6'b100010);
   localparam logic [NB_SEL-1:0] SEL_LATCH0 = NB_SEL'(6'b100100);

   localparam logic [15:0] IDX_PC     = 16'(NB_GPR);
   localparam logic [15:0] IDX_LATCH0 = 16'(NB_GPR + 1);
   localparam logic [15:0] IDX_LATCHN = 16'(NB_GPR + 8);
   localparam logic [15:0] IDX_MEM0   = 16'(NB_GPR + 9);
   localparam logic [15:0] IDX_LAST   = 16'(N_ITEMS - 1);
   localparam logic [WW-1:0] WC_MAX   = WW'(MAX_WORDS);
   localparam logic [CW-1:0] C_DEPTH  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] C_SPACE  = CW'(SPACE);

   logic [2:0]             r_state;
   logic [15:0]            r_idx;
   logic [WW-1:0]          r_word_cnt;
   logic                   r_overrun;
   logic [NB_MEM_ADDR-1:0] r_mem_addr;

   logic [NB_DATA-1:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [CW-1:0]          r_count;

   logic [NB_SEL-1:0]      w_item_sel;
   logic                   w_is_mem;
   logic [NB_MEM_ADDR-1:0] w_mem_k;
   logic                   w_space_ok;
   logic                   w_push;
   logic                   w_pop;
   logic [NB_DATA-1:0]     w_push_data;

   // Item index -> select/address decode, in dump order
   always_comb begin
      w_is_mem = 1'b0;
      w_mem_k  = '0;
      if (r_idx < IDX_PC) begin
         w_item_sel = NB_SEL'({1'b0, r_idx[4:0]});
      end else if (r_idx == IDX_PC) begin
         w_item_sel = SEL_PC;
      end else if (r_idx <= IDX_LATCHN) begin
         w_item_sel = SEL_LATCH0 + NB_SEL'(r_idx - IDX_LATCH0);
      end else begin
         w_item_sel = SEL_MEM;
         w_is_mem   = 1'b1;
         w_mem_k    = NB_MEM_ADDR'(r_idx - IDX_MEM0);
      end
   end

   assign w_space_ok = (C_DEPTH - r_count) >= C_SPACE;
   assign w_pop      = (r_count != '0) && i_fifo_ready;

   always_comb begin
      w_push      = 1'b0;
      w_push_data = i_data_from_mips;
`ifdef MIPS_DUMP_HEADER_EN
      if (r_state == S_REQ) begin
         w_push      = 1'b1;
         w_push_data = NB_DATA'({8'hA5, 2'b00, w_item_sel, r_idx});
      end
`endif
      // A word arriving after MAX_WORDS without eod is the overrun marker, not data
      if (r_state == S_CAP && !i_eod && r_word_cnt != WC_MAX)
         w_push = 1'b1;
      if (i_abort)
         w_push = 1'b0;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_word_cnt <= '0;
         r_overrun  <= 1'b0;
         r_mem_addr <= '0;
      end else if (i_abort) begin
         r_state    <= S_IDLE;
         r_word_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state   <= S_WAIT;
                  r_idx     <= '0;
                  r_overrun <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (w_space_ok) begin
                  r_state    <= S_REQ;
                  r_word_cnt <= '0;
                  if (w_is_mem)
                     r_mem_addr <= w_mem_k;
               end
            end
            S_REQ: r_state <= S_CAP;
            S_CAP: begin
               if (i_eod) begin
                  r_state <= S_NEXT;
               end else if (r_word_cnt == WC_MAX) begin
                  r_overrun <= 1'b1;
                  r_state   <= S_NEXT;
               end else begin
                  r_word_cnt <= r_word_cnt + 1'b1;
               end
            end
            S_NEXT: begin
               if (r_idx == IDX_LAST) begin
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + 16'd1;
                  r_state <= S_WAIT;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_push_data;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset || i_abort) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_request_select = (r_state == S_REQ) ? w_item_sel : SEL_NONE;
   assign o_mem_addr       = r_mem_addr;
   assign o_fifo_data      = r_mem[r_rd_ptr];
   assign o_fifo_valid     = (r_count != '0);
   assign o_fifo_count     = r_count;
   assign o_busy           = (r_state == S_WAIT) || (r_state == S_REQ) ||
                             (r_state == S_CAP)  || (r_state == S_NEXT);
   assign o_done           = (r_state == S_DONE);
   assign o_overrun        = r_overrun;

endmodule
